// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op encodings, FSM states and
// the helper that sizes the shift-amount field from the operand width.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_MUL = 4'b0011,
    OP_SUB = 4'b0110,
    OP_SLL = 4'b0111,
    OP_SRL = 4'b1000,
    OP_SRA = 4'b1001,
    OP_NOR = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Number of low operand-B bits that form a shift amount.
  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: loads on start, performs one step per edge
// and pulses done during the last step, with the final product alongside.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = shamt_w(WIDTH);

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic [WIDTH-1:0] step_s;
  logic             last_s;

  assign step_s  = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
  assign last_s  = busy_r && (cnt_r == CW'(WIDTH - 1));
  assign done    = last_s;
  assign product = step_s;

  // Operand capture on start, then one shift-add step per edge until the last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      acc_r    <= step_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
      busy_r   <= !last_s;
    end else begin
      busy_r   <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// ALU with single-cycle logic/arith/shift ops and an optional iterative
// multiply, valid/ready handshaking on both sides and registered results.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             is_greater,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHW = shamt_w(WIDTH);

  alu_state_e       state_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             gt_r;
  logic             ovf_r;
  logic             ill_r;
  logic             gt_pend_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             is_mul_s;
  logic             mul_start_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_prod_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] res_s;
  logic             ovf_s;
  logic             ill_s;

  assign shamt_s     = b[SHW-1:0];
  assign sum_s       = a + b;
  assign diff_s      = a - b;
  assign accept_s    = in_valid && in_ready_s;
  assign is_mul_s    = (alu_op == OP_MUL) && (MUL_EN != 0);
  assign mul_start_s = accept_s && is_mul_s;

  // Ready decode: free when idle, pass-through of the consumer while done.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_DONE: in_ready_s = out_ready;
      ST_MUL:  in_ready_s = 1'b0;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Single-cycle datapath; MUL only lands here when the multiplier is absent.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    ovf_s = 1'b0;
    ill_s = 1'b0;
    case (alu_op)
      OP_AND: res_s = a & b;
      OP_OR:  res_s = a | b;
      OP_NOR: res_s = ~(a | b);
      OP_ADD: begin
        res_s = sum_s;
        ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = diff_s;
        ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL: res_s = a << shamt_s;
      OP_SRL: res_s = a >> shamt_s;
      OP_SRA: res_s = $unsigned($signed(a) >>> shamt_s);
      OP_MUL: ill_s = 1'b1;
      default: ill_s = 1'b1;
    endcase
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (mul_prod_s)
      );
    end else begin : g_no_mul
      assign mul_done_s = 1'b0;
      assign mul_prod_s = {WIDTH{1'b0}};
    end
  endgenerate

  // Control FSM with registered result and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      gt_r        <= 1'b0;
      ovf_r       <= 1'b0;
      ill_r       <= 1'b0;
      gt_pend_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s && is_mul_s) begin
            state_r     <= ST_MUL;
            out_valid_r <= 1'b0;
            gt_pend_r   <= (a > b);
          end else if (accept_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            result_r    <= res_s;
            zero_r      <= (res_s == {WIDTH{1'b0}});
            gt_r        <= (a > b);
            ovf_r       <= ovf_s;
            ill_r       <= ill_s;
          end else if ((state_r == ST_DONE) && out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= state_r;
            out_valid_r <= out_valid_r;
          end
        end
        ST_MUL: begin
          // The flag from accept time travels with the product.
          if (mul_done_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            result_r    <= mul_prod_s;
            zero_r      <= (mul_prod_s == {WIDTH{1'b0}});
            gt_r        <= gt_pend_r;
            ovf_r       <= 1'b0;
            ill_r       <= 1'b0;
          end else begin
            state_r     <= ST_MUL;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign result     = result_r;
  assign zero       = zero_r;
  assign is_greater = gt_r;
  assign overflow   = ovf_r;
  assign illegal    = ill_r;

endmodule
